// File: rtl/uart_pkg.sv
// Shared UART types and default constants for the TX serializer and the future RX stage.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int UART_DATA_WIDTH   = 8;
    localparam int UART_CLKS_PER_BIT = 16;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read handshake between the FIFO (slave) and the serializer (master).
interface uart_tx_serializer_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) ();

    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;

    modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
    modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running baud counter; o_bit_end marks the last clock of each serial bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_restart || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops words from the TX FIFO and shifts out start, data (LSB first),
// optional parity and stop bits on a registered tx line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.master fifo,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    tx_state_t             r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_parity, w_parity_nxt;
    logic [BW-1:0]         r_bit_cnt;
    logic                  r_tx, w_tx_nxt;
    logic                  w_restart, w_bit_end, w_last_data, w_last_stop;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_bit_end (w_bit_end)
    );

    assign w_last_data = w_bit_end && (r_bit_cnt == BW'(DATA_WIDTH - 1));
    assign w_last_stop = (r_state == STOP) && w_bit_end && (r_bit_cnt == BW'(STOP_BITS - 1));

    assign tx              = r_tx;
    assign busy            = (r_state != IDLE);
    assign tx_done         = w_last_stop;
    assign fifo.fifo_rd_en = (r_state == POP);

    // Timer is held at zero outside the bit states so START always begins a full period.
    always_comb begin
        w_state_nxt = r_state;
        w_restart   = 1'b0;
        case (r_state)
            IDLE: begin
                w_restart = 1'b1;
                if (!fifo.fifo_empty) w_state_nxt = POP;
            end
            POP: begin
                w_restart   = 1'b1;
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_restart   = 1'b1;
                w_state_nxt = START;
            end
            START:  if (w_bit_end) w_state_nxt = DATA;
            DATA:   if (w_last_data) w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (w_bit_end) w_state_nxt = STOP;
            STOP:   if (w_last_stop) w_state_nxt = fifo.fifo_empty ? IDLE : POP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // tx is computed from the next state so the registered line lines up with the state.
    always_comb begin
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = 1'b1;
        if (r_state == LOAD) begin
            w_shift_nxt  = fifo.fifo_data;
            w_parity_nxt = calc_parity(fifo.fifo_data);
        end else if ((r_state == DATA) && w_bit_end) begin
            w_shift_nxt = r_shift >> 1;
        end
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PARITY:  w_tx_nxt = w_parity_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            if (r_state == LOAD) begin
                r_bit_cnt <= '0;
            end else if ((r_state == DATA) && w_bit_end) begin
                r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BW'(1);
            end else if ((r_state == STOP) && w_bit_end) begin
                r_bit_cnt <= w_last_stop ? '0 : r_bit_cnt + BW'(1);
            end
        end
    end

endmodule
